// File: rtl/uart_pkg.sv
// Shared UART definitions: default framing constants, receiver state encoding
// and the 2-of-3 vote used by the oversampling front end.
package uart_pkg;

  localparam int unsigned OVERSAMPLING_DEF = 8;
  localparam int unsigned DATA_BITS_DEF    = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Receive front end: brings the async line into the clock domain and keeps a
// 3-sample history, advanced only on oversampling ticks, for noise voting.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic sysclk_in,
  input  logic nrst_in,
  input  logic divpulse_in,
  input  logic serial_in,
  output logic synced_out,
  output logic majority_out
);

  logic       sync1_q;
  logic       sync2_q;
  logic [2:0] hist_q;

  // Reset to the idle (high) level so no spurious low appears after reset.
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      if (divpulse_in) begin
        hist_q <= {hist_q[1:0], sync2_q};
      end
    end
  end

  assign synced_out   = sync2_q;
  assign majority_out = maj3(hist_q);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop framing FSM driven by baud ticks,
// LSB-first shift register, one-cycle done and frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLING = OVERSAMPLING_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 sysclk_in,
  input  logic                 nrst_in,
  input  logic                 divpulse_in,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_done_out,
  output logic                 rx_busy_out,
  output logic                 rx_frame_err_out
);

  localparam int unsigned TW = $clog2(OVERSAMPLING);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLING / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 armed_q, armed_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic line_synced;
  logic line_maj;

  uart_rx_sync u_sync (
    .sysclk_in    (sysclk_in),
    .nrst_in      (nrst_in),
    .divpulse_in  (divpulse_in),
    .serial_in    (rx_serial_in),
    .synced_out   (line_synced),
    .majority_out (line_maj)
  );

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (line_synced) armed_d = 1'b1;
        if (divpulse_in && armed_q && !line_synced) begin
          state_d = RX_START;
          tick_d  = '0;
          armed_d = 1'b0;
        end
      end
      RX_START: begin
        if (divpulse_in) begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = line_maj ? RX_IDLE : RX_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      RX_DATA: begin
        if (divpulse_in) begin
          if (tick_q == TICK_LAST) begin
            shreg_d = {line_maj, shreg_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) state_d = RX_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      RX_STOP: begin
        if (divpulse_in) begin
          if (tick_q == TICK_LAST) begin
            if (line_maj) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            tick_d  = '0;
            armed_d = 1'b0;
            state_d = RX_IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Back to idle at mid-stop so a following start edge half a bit later is caught.
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_data_out      = data_q;
  assign rx_done_out      = done_q;
  assign rx_frame_err_out = err_q;
  assign rx_busy_out      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial driver pushes expected frames to a
// scoreboard queue, a monitor pops and compares on every done/error strobe.
module tb_uart_rx;

  localparam int TICK = 16;
  localparam int OVS  = 8;
  localparam int BIT  = TICK * OVS;

  logic       clk      = 1'b0;
  logic       nrst     = 1'b0;
  logic       divpulse = 1'b0;
  logic       rx       = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_err;

  uart_rx #(.OVERSAMPLING(OVS), .DATA_BITS(8)) dut (
    .sysclk_in        (clk),
    .nrst_in          (nrst),
    .divpulse_in      (divpulse),
    .rx_serial_in     (rx),
    .rx_data_out      (rx_data),
    .rx_done_out      (rx_done),
    .rx_busy_out      (rx_busy),
    .rx_frame_err_out (rx_err)
  );

  always #5 clk = ~clk;

  int div_cnt = 0;
  always @(negedge clk) begin
    div_cnt  = (div_cnt == TICK - 1) ? 0 : div_cnt + 1;
    divpulse = (div_cnt == TICK - 1);
  end

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;

  int      n_cmp = 0;
  int      n_bad = 0;
  int      done_cnt = 0;
  int      err_cnt = 0;
  longint  cyc = 0;
  longint  frame_start_cyc = 0;
  longint  busy_rise_cyc = 0;
  longint  done_cyc[$];
  logic    prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (nrst) begin
      if (rx_busy && !prev_busy) busy_rise_cyc = cyc;
      if (rx_done && rx_err) begin
        check("done_and_err_together", 32'({rx_done, rx_err}), 32'h1);
      end else if (rx_done || rx_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'({rx_done, rx_err}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_err", 32'(rx_err), 32'(e.is_err));
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("busy_before_strobe", 32'(prev_busy), 32'h1);
        end
      end
      if (rx_done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (rx_err) err_cnt++;
    end
    prev_busy = rx_busy;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int spike_bit);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = stop_ok ? b : last_good;
    if (stop_ok) last_good = b;
    exp_q.push_back(e);
    frame_start_cyc = cyc;
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == spike_bit) begin
        wait_cyc(BIT / 2 - TICK / 2);
        rx = ~b[i];
        wait_cyc(TICK);
        rx = b[i];
        wait_cyc(BIT / 2 - TICK / 2);
      end else begin
        wait_cyc(BIT);
      end
    end
    rx = stop_ok;
    wait_cyc(BIT);
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      wait_cyc(1);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     d0, e0;
    longint lat, delta;
    bit     saw_busy;
    logic [7:0] aborted;

    nrst = 1'b0;
    rx   = 1'b1;
    wait_cyc(5);
    check("reset_data", 32'(rx_data), 32'h0);
    check("reset_done", 32'(rx_done), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    check("reset_err",  32'(rx_err),  32'h0);
    nrst = 1'b1;
    wait_cyc(BIT + 7);

    // Single frame, latency and busy window
    send_frame(8'h61, 1'b1, -1);
    wait_drained(2 * BIT);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_err_count",  32'(err_cnt),  32'd0);
    lat = done_cyc[0] - frame_start_cyc;
    check("t1_latency_in_window",
          32'((lat >= longint'(BIT * 19 / 2 - TICK)) && (lat <= longint'(BIT * 19 / 2 + 3 * TICK))), 32'h1);
    delta = busy_rise_cyc - frame_start_cyc;
    check("t1_busy_rise_in_window", 32'((delta >= 0) && (delta <= longint'(5 * TICK))), 32'h1);
    check("t1_busy_after_done", 32'(rx_busy), 32'h0);

    // Back-to-back frames with a single stop bit
    send_frame(8'h62, 1'b1, -1);
    send_frame(8'h63, 1'b1, -1);
    wait_drained(2 * BIT);
    check("t2_done_count", 32'(done_cnt), 32'd3);
    delta = done_cyc[2] - done_cyc[1];
    check("t2_spacing_10_bits",
          32'((delta >= longint'(10 * BIT - 2 * TICK)) && (delta <= longint'(10 * BIT + 2 * TICK))), 32'h1);
    check("t2_data_held", 32'(rx_data), 32'h63);
    wait_cyc(BIT);

    // Two-tick glitch: false start, no strobes
    d0 = done_cnt;
    e0 = err_cnt;
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 2 * TICK; i++) begin
      wait_cyc(1);
      saw_busy |= rx_busy;
    end
    rx = 1'b1;
    for (int i = 0; i < 2 * BIT; i++) begin
      wait_cyc(1);
      saw_busy |= rx_busy;
    end
    check("t3_busy_pulsed", 32'(saw_busy), 32'h1);
    check("t3_back_idle",   32'(rx_busy), 32'h0);
    check("t3_no_done",     32'(done_cnt - d0), 32'd0);
    check("t3_no_err",      32'(err_cnt - e0), 32'd0);

    // Bad stop bit followed by a break, then recovery
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h64, 1'b0, -1);
    rx = 1'b0;
    wait_cyc(3 * BIT);
    rx = 1'b1;
    wait_cyc(BIT);
    check("t4_one_err",    32'(err_cnt - e0), 32'd1);
    check("t4_no_done",    32'(done_cnt - d0), 32'd0);
    check("t4_data_kept",  32'(rx_data), 32'h63);
    send_frame(8'h2E, 1'b1, -1);
    wait_drained(2 * BIT);
    check("t4_recovered", 32'(rx_data), 32'h2E);
    wait_cyc(BIT);

    // Reset in the middle of data bit 3
    aborted = 8'h5A;
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = aborted[i];
      wait_cyc(BIT);
    end
    rx = aborted[3];
    wait_cyc(BIT / 2);
    nrst = 1'b0;
    wait_cyc(1);
    nrst = 1'b1;
    rx   = 1'b1;
    check("t5_reset_data", 32'(rx_data), 32'h0);
    check("t5_reset_busy", 32'(rx_busy), 32'h0);
    check("t5_reset_done", 32'(rx_done), 32'h0);
    check("t5_reset_err",  32'(rx_err),  32'h0);
    last_good = 8'h00;
    d0 = done_cnt;
    e0 = err_cnt;
    wait_cyc(12 * BIT);
    check("t5_no_strobes", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    send_frame(8'h2E, 1'b1, -1);
    wait_drained(2 * BIT);
    check("t5_recovered", 32'(rx_data), 32'h2E);
    wait_cyc(BIT);

    // One-tick inverted spike at the middle of data bit 2
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 2);
    wait_drained(2 * BIT);
    check("t6_spike_rejected", 32'(rx_data), 32'hA5);
    check("t6_one_done",       32'(done_cnt - d0), 32'd1);

    wait_cyc(BIT);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
